// File: rtl/memory_responder.sv
// memory_responder: word-addressed memory that answers the control unit's
// Read/Write request edges after a fixed number of wait states. Each access
// ends with a one-cycle Ready pulse. Err pulses on a simultaneous Read/Write
// request.
// Optional feature macro: WRITE_PROTECT_EN. When it is defined, writes at or
// above PROTECT_BASE are dropped and flagged with Err alongside Ready.
module memory_responder #(
  parameter int          ADDR_W       = 9,
  parameter int          DATA_W       = 32,
  parameter int          WAIT_CYCLES  = 2,
  parameter int unsigned PROTECT_BASE = 'h1C0
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut,
  output logic              Busy,
  output logic              Ready,
  output logic              Err
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rd_prev_q, wr_prev_q;
  logic              rd_edge, wr_edge;
  logic              start, collide;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              op_wr_q;
  logic [DATA_W-1:0] dout_q;
  logic              err_q;
  logic              wr_blocked;
  logic              mem_we;

  logic [DATA_W-1:0] mem [DEPTH];

  // A request is a 0->1 transition against the level seen on the previous edge.
  assign rd_edge = Read  & ~rd_prev_q;
  assign wr_edge = Write & ~wr_prev_q;

`ifdef WRITE_PROTECT_EN
  // Writes into the protected top region are silently dropped but flagged.
  assign wr_blocked = (addr_q >= PROTECT_BASE[ADDR_W-1:0]);
`else
  logic unused_protect_base;
  assign unused_protect_base = ^PROTECT_BASE;
  assign wr_blocked = 1'b0;
`endif

  // Next-state and wait-counter logic for the request sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    collide = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rd_edge && wr_edge) begin
          collide = 1'b1;
        end else if (rd_edge || wr_edge) begin
          start = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = S_ACCESS;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACCESS: state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Sequencer state, edge detectors, request latches, read data and Err pulse.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      rd_prev_q <= 1'b0;
      wr_prev_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      op_wr_q   <= 1'b0;
      dout_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_prev_q <= Read;
      wr_prev_q <= Write;
      if (start) begin
        addr_q  <= Address;
        data_q  <= DataIn;
        op_wr_q <= wr_edge;
      end
      if (state_q == S_ACCESS && !op_wr_q) begin
        dout_q <= mem[addr_q];
      end
      err_q <= collide | (state_q == S_ACCESS && op_wr_q && wr_blocked);
    end
  end

  // Storage is never reset; a write lands only on the ACCESS edge of a live op.
  assign mem_we = Resetn && (state_q == S_ACCESS) && op_wr_q && !wr_blocked;

  // Storage write port.
  always_ff @(posedge Clock) begin
    if (mem_we) begin
      mem[addr_q] <= data_q;
    end
  end

  assign DataOut = dout_q;
  assign Busy    = (state_q == S_WAIT) || (state_q == S_ACCESS);
  assign Ready   = (state_q == S_DONE);
  assign Err     = err_q;

endmodule

// File: tb/tb_memory_responder.sv
// Testbench for memory_responder: directed request sequences checked against
// a transaction-level model (completion edge = accept edge + W + 1) every
// cycle, plus literal expectations for the key scenarios.
module tb_memory_responder;

  localparam int W = 2;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        Read = 1'b0;
  logic        Write = 1'b0;
  logic [8:0]  Address = '0;
  logic [31:0] DataIn = '0;
  logic [31:0] DataOut;
  logic        Busy, Ready, Err;

  int n_checks = 0;
  int n_err = 0;

  memory_responder #(
    .ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(W), .PROTECT_BASE('h1C0)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .Read(Read), .Write(Write),
    .Address(Address), .DataIn(DataIn), .DataOut(DataOut),
    .Busy(Busy), .Ready(Ready), .Err(Err)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit prot(input logic [8:0] a);
`ifdef WRITE_PROTECT_EN
    return a >= 9'h1C0;
`else
    return (a == 9'h000) && (a != 9'h000);
`endif
  endfunction

  // ---------------- transaction-level model ----------------
  logic [31:0] mmem [512];
  bit          mknown [512];
  int          ecount = 0;
  bit          m_active = 0;
  int          m_acc, m_done;
  bit          m_wr;
  logic [8:0]  m_addr;
  logic [31:0] m_data;
  bit          m_prev_rd = 0, m_prev_wr = 0;
  bit          rde, wre;
  logic [31:0] exp_dout = '0;
  bit          dout_known = 1;
  bit          exp_busy = 0, exp_ready = 0, exp_err = 0;

  always @(posedge Clock) begin
    if (!Resetn) begin
      m_active  = 0;
      m_prev_rd = 0;
      m_prev_wr = 0;
      exp_dout  = '0;
      dout_known = 1;
      exp_busy  = 0;
      exp_ready = 0;
      exp_err   = 0;
    end else begin
      ecount++;
      rde = Read && !m_prev_rd;
      wre = Write && !m_prev_wr;
      m_prev_rd = Read;
      m_prev_wr = Write;
      exp_err = 0;
      if (m_active && ecount == m_done) begin
        if (m_wr) begin
          if (!prot(m_addr)) begin
            mmem[m_addr]   = m_data;
            mknown[m_addr] = 1;
          end
        end else begin
          exp_dout   = mmem[m_addr];
          dout_known = mknown[m_addr];
        end
      end
      if (!m_active || ecount >= m_done + 2) begin
        if (rde && wre) begin
          exp_err = 1;
        end else if (rde || wre) begin
          m_active = 1;
          m_acc    = ecount;
          m_done   = ecount + W + 1;
          m_wr     = wre;
          m_addr   = Address;
          m_data   = DataIn;
        end
      end
      exp_busy  = m_active && ecount >= m_acc && ecount < m_done;
      exp_ready = m_active && ecount == m_done;
      if (exp_ready && m_wr && prot(m_addr)) exp_err = 1;
    end
    #1;
    check("model_busy", Busy, exp_busy);
    check("model_ready", Ready, exp_ready);
    check("model_err", Err, exp_err);
    if (dout_known) check("model_dout", DataOut, exp_dout);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge Clock);
    #2;
  endtask

  task automatic do_op(input logic rd, input logic wr, input logic [8:0] a, input logic [31:0] d);
    Address = a;
    DataIn  = d;
    Read    = rd;
    Write   = wr;
    step();
    Read    = 0;
    Write   = 0;
    Address = 9'($urandom);
    DataIn  = $urandom;
    repeat (W + 3) step();
  endtask

  int rdy_cnt;

  initial begin
    repeat (3) step();
    check("rst_busy", Busy, 1'b0);
    check("rst_ready", Ready, 1'b0);
    check("rst_err", Err, 1'b0);
    check("rst_dout", DataOut, 32'h0);
    Resetn = 1;
    step();

    // Write 0xDEADBEEF to 0x004 with literal latency checks.
    Address = 9'h004; DataIn = 32'hDEADBEEF; Write = 1;
    step();
    check("wr_busy_k", Busy, 1'b1);
    Write = 0; Address = 9'($urandom); DataIn = $urandom;
    step();
    check("wr_ready_k1", Ready, 1'b0);
    step();
    check("wr_ready_k2", Ready, 1'b0);
    check("wr_busy_k2", Busy, 1'b1);
    step();
    check("wr_ready_k3", Ready, 1'b1);
    check("wr_err_k3", Err, 1'b0);
    check("wr_busy_k3", Busy, 1'b0);
    step();
    check("wr_ready_k4", Ready, 1'b0);

    // Read it back; DataOut holds after Read drops.
    Address = 9'h004; Read = 1;
    step();
    Address = 9'($urandom);
    repeat (3) step();
    check("rd_ready_k3", Ready, 1'b1);
    check("rd_dout_k3", DataOut, 32'hDEADBEEF);
    Read = 0;
    repeat (3) step();
    check("rd_dout_hold", DataOut, 32'hDEADBEEF);

    // Seed a few words, including the highest address.
    do_op(0, 1, 9'h010, 32'hA5A50010);
    do_op(0, 1, 9'h020, 32'h11112222);
    do_op(0, 1, 9'h1FF, 32'h0F0F1FF0);
    do_op(1, 0, 9'h1FF, 32'h0);
`ifndef WRITE_PROTECT_EN
    check("top_addr_dout", DataOut, 32'h0F0F1FF0);
`endif
    do_op(0, 1, 9'h000, 32'h00C0FFEE);
    do_op(1, 0, 9'h000, 32'h0);
    check("addr0_dout", DataOut, 32'h00C0FFEE);

    // Simultaneous Read and Write rise.
    Address = 9'h010; DataIn = 32'hFFFFFFFF; Read = 1; Write = 1;
    step();
    check("coll_err", Err, 1'b1);
    check("coll_ready", Ready, 1'b0);
    check("coll_busy", Busy, 1'b0);
    Read = 0; Write = 0;
    step();
    check("coll_err_clr", Err, 1'b0);
    repeat (3) step();
    do_op(1, 0, 9'h010, 32'h0);
    check("coll_word_kept", DataOut, 32'hA5A50010);

    // Second edge while busy, then a long held level: one Ready total.
    rdy_cnt = 0;
    Address = 9'h004; Read = 1;
    step();
    rdy_cnt += int'(Ready);
    Read = 0;
    step();
    rdy_cnt += int'(Ready);
    Read = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      rdy_cnt += int'(Ready);
    end
    Read = 0;
    step();
    rdy_cnt += int'(Ready);
    check("one_ready", rdy_cnt, 1);

    // Reset during the WAIT of a write to 0x020.
    Address = 9'h020; DataIn = 32'h12345678; Write = 1;
    step();
    Write = 0;
    step();
    #1 Resetn = 0;
    #1;
    check("abort_busy", Busy, 1'b0);
    check("abort_ready", Ready, 1'b0);
    check("abort_err", Err, 1'b0);
    check("abort_dout", DataOut, 32'h0);
    repeat (2) step();
    Resetn = 1;
    step();
    do_op(1, 0, 9'h020, 32'h0);
    check("abort_word_kept", DataOut, 32'h11112222);

    // Read already high when reset releases counts as an edge.
    Resetn = 0;
    repeat (2) step();
    Address = 9'h004; Read = 1;
    Resetn = 1;
    step();
    check("post_rst_busy", Busy, 1'b1);
    Read = 0;
    repeat (W + 3) step();
    check("post_rst_dout", DataOut, 32'hDEADBEEF);

    // Write to the first protectable address.
    do_op(0, 1, 9'h1C0, 32'hCAFEF00D);
    do_op(1, 0, 9'h1C0, 32'h0);
`ifndef WRITE_PROTECT_EN
    check("prot_base_dout", DataOut, 32'hCAFEF00D);
`endif

    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter ADDR_W, default 9, word-address width (512 words).
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter WAIT_CYCLES, default 2, range 0..15, wait states inserted before each access.
REQ-004 Parameter PROTECT_BASE, default 9'h1C0, lowest write-protected word address.
REQ-005 Clock  input  1  single clock, rising-edge active; one clock; all state changes on rising Clock.
REQ-006 Resetn  input  1  reset, asynchronous, active-low.
REQ-007 Read  input  1  read request level from control unit.
REQ-008 Write  input  1  write request level from control unit.
REQ-009 Address  input  ADDR_W  word address, taken from MAR low bits.
REQ-010 DataIn  input  DATA_W  write data, taken from MDR.
REQ-011 DataOut  output  DATA_W  read data returned to MDR.
REQ-012 Busy  output  1  high while a request is in progress.
REQ-013 Ready  output  1  one-cycle completion pulse.
REQ-014 Err  output  1  one-cycle error pulse.

Function
REQ-015 States: IDLE, WAIT, ACCESS, DONE; encoding is free.
REQ-016 A request is a rising edge of Read or Write, detected against the value registered on the previous clock. Levels held high do not retrigger.
REQ-017 In IDLE, on a request edge: latch Address, DataIn and the operation; set Busy=1; go to WAIT. If WAIT_CYCLES=0, go directly to ACCESS.
REQ-018 WAIT: a down-counter loaded with WAIT_CYCLES. Go to ACCESS on the edge where the counter reaches 1.
REQ-019 ACCESS, write: store the latched data at the latched address. ACCESS, read: register the addressed word into DataOut. Next state is DONE.
REQ-020 DONE: Ready=1 for exactly one cycle, Busy=0, next state IDLE.
REQ-021 Latency: with the request sampled at edge k, Ready is high in the cycle following edge k+WAIT_CYCLES+1; DataOut is valid from that same edge.
REQ-022 Request edges arriving while Busy=1 or in DONE are ignored: no queueing, no Err.
REQ-023 Read and Write rising on the same edge: no access, Err=1 for one cycle, Ready=0, state stays IDLE.
REQ-024 DataOut holds its last read value until the next read completes. Writes do not change DataOut.
REQ-025 Latched address and data are immune to Address/DataIn changes after the sampling edge.
REQ-026 Highest address (all ones) is fully accessible. There is no address wrap: the address is exactly ADDR_W bits.

Reset
REQ-027 Resetn low, at any time including mid-operation: state=IDLE, Busy=0, Ready=0, Err=0, DataOut=0, wait counter=0, edge-detect registers=0.
REQ-028 An aborted write leaves storage unmodified. Storage contents are not cleared by reset.
REQ-029 After Resetn deasserts, Read or Write already high is treated as an edge on the first clock (prev registers are 0).

Configuration
REQ-030 Macro WRITE_PROTECT_EN.
- Defined: a write to an address >= PROTECT_BASE does not modify storage. It still completes with the normal latency, and Err=1 in the same cycle as Ready.
- Undefined: all addresses are writable, and Err is raised only per REQ-023.

Verification
REQ-031 Reset, then Write edge with Address=9'h004, DataIn=32'hDEADBEEF, WAIT_CYCLES=2 -> Busy high from next edge, Ready pulse in the cycle after edge k+3, Err=0.
REQ-032 Read edge at 9'h004 -> DataOut=32'hDEADBEEF with Ready at edge k+3; DataOut holds after Read drops.
REQ-033 Read and Write rising together at 9'h010 -> Err one cycle, no Ready, the word at 9'h010 is unchanged on a later read.
REQ-034 Second Read edge while Busy; then Read held high for 10 cycles -> exactly one Ready total.
REQ-035 Resetn pulsed low during WAIT of a write of 32'h12345678 to 9'h020 -> outputs 0 immediately; a later read of 9'h020 returns the prior contents.
REQ-036 With WRITE_PROTECT_EN: write 32'hCAFEF00D to 9'h1C0 -> Ready+Err together, and a read returns the old value. Without the macro, the read returns 32'hCAFEF00D and Err stays 0.
